// File: rtl/store_txn_gen.sv
// Splits one nibble-granular store request into 4 KiB-safe AXI INCR bursts.
// Emits one AW per burst, then one txn_ctrl record per W beat.
module store_txn_gen #(
    parameter int AxiDataWidth = 128,
    parameter int AxiAddrWidth = 64,
    parameter int AxiIdWidth   = 4,
    parameter int LenWidth     = 32,
    localparam int BusNibbles  = AxiDataWidth / 4,
    localparam int BusNSize    = $clog2(BusNibbles)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AxiAddrWidth:0]   req_nb_addr_i,
    input  logic [LenWidth-1:0]     req_nr_nbs_i,
    input  logic [AxiIdWidth-1:0]   req_id_i,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [AxiAddrWidth-1:0] aw_addr_o,
    output logic [7:0]              aw_len_o,
    output logic [2:0]              aw_size_o,
    output logic [1:0]              aw_burst_o,
    output logic [AxiIdWidth-1:0]   aw_id_o,
    output logic                    txn_ctrl_valid_o,
    input  logic                    txn_ctrl_ready_i,
    output logic [AxiAddrWidth:0]   txn_addr_o,
    output logic                    txn_is_head_o,
    output logic [7:0]              txn_rmn_beat_o,
    output logic [BusNSize:0]       txn_lbn_o,
    output logic                    txn_is_final_txn_o,
    output logic                    busy_o
);

    localparam int AxiSize = $clog2(AxiDataWidth / 8);
    localparam int CalcW   = LenWidth + 1;
    localparam int NbAddrW = AxiAddrWidth + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_AW, S_BEAT} state_e;

    state_e                  state;
    logic [NbAddrW-1:0]      cur_addr;
    logic [LenWidth-1:0]     rmn_nbs;
    logic [LenWidth-1:0]     txn_nbs;
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] aw_addr;
    logic [7:0]              aw_len;
    logic [7:0]              rmn_beat;
    logic                    is_head;
    logic                    is_final;
    logic [BusNSize:0]       lbn;
    logic [8:0]              beat_cnt;

    logic [CalcW-1:0] off, to4k, maxb, txn_c, sum;

    // Burst size: clipped by request remainder, 4 KiB page and 256 beats.
    always_comb begin
        off   = CalcW'(cur_addr[BusNSize-1:0]);
        to4k  = CalcW'(8192) - CalcW'(cur_addr[12:0]);
        maxb  = CalcW'(256 * BusNibbles) - off;
        txn_c = CalcW'(rmn_nbs);
        if (to4k < txn_c) txn_c = to4k;
        if (maxb < txn_c) txn_c = maxb;
        sum   = off + txn_c;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            cur_addr <= '0;
            rmn_nbs  <= '0;
            txn_nbs  <= '0;
            id       <= '0;
            aw_addr  <= '0;
            aw_len   <= '0;
            rmn_beat <= '0;
            is_head  <= 1'b0;
            is_final <= 1'b0;
            lbn      <= '0;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        cur_addr <= req_nb_addr_i;
                        rmn_nbs  <= req_nr_nbs_i;
                        id       <= req_id_i;
                        if (req_nr_nbs_i != '0) state <= S_CALC;
                    end
                end
                S_CALC: begin
                    txn_nbs  <= txn_c[LenWidth-1:0];
                    aw_addr  <= {cur_addr[NbAddrW-1:AxiSize+1], {AxiSize{1'b0}}};
                    aw_len   <= 8'((sum - CalcW'(1)) >> BusNSize);
                    rmn_beat <= 8'((sum - CalcW'(1)) >> BusNSize);
                    lbn      <= (sum[BusNSize-1:0] == '0) ? (BusNSize+1)'(BusNibbles)
                                                          : {1'b0, sum[BusNSize-1:0]};
                    is_final <= (txn_c == CalcW'(rmn_nbs));
                    is_head  <= 1'b1;
                    beat_cnt <= '0;
                    state    <= S_AW;
                end
                S_AW: begin
                    if (aw_ready_i) state <= S_BEAT;
                end
                S_BEAT: begin
                    if (txn_ctrl_ready_i) begin
                        is_head  <= 1'b0;
                        rmn_beat <= rmn_beat - 8'd1;
                        beat_cnt <= beat_cnt + 9'd1;
                        if (rmn_beat == 8'd0) begin
                            if (is_final) begin
                                state <= S_IDLE;
                            end else begin
                                cur_addr <= cur_addr + NbAddrW'(txn_nbs);
                                rmn_nbs  <= rmn_nbs - txn_nbs;
                                state    <= S_CALC;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o        = (state == S_IDLE);
    assign busy_o             = (state != S_IDLE);
    assign aw_valid_o         = (state == S_AW);
    assign aw_addr_o          = aw_addr;
    assign aw_len_o           = aw_len;
    assign aw_size_o          = 3'(AxiSize);
    assign aw_burst_o         = 2'b01;
    assign aw_id_o            = id;
    assign txn_ctrl_valid_o   = (state == S_BEAT);
    assign txn_addr_o         = cur_addr;
    assign txn_is_head_o      = is_head;
    assign txn_rmn_beat_o     = rmn_beat;
    assign txn_lbn_o          = lbn;
    assign txn_is_final_txn_o = is_final;

    logic [15:0] aw_end;
    assign aw_end = 16'(aw_addr[11:0]) + ((16'(aw_len) + 16'd1) << AxiSize);

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (txn_ctrl_valid_o)
                assert (lbn != '0 && lbn <= (BusNSize+1)'(BusNibbles));
            if (aw_valid_o)
                assert (aw_end <= 16'd4096);
            if (txn_ctrl_valid_o && txn_ctrl_ready_i && rmn_beat == 8'd0)
                assert (beat_cnt == {1'b0, aw_len});
        end
    end

endmodule

// File: tb/tb_store_txn_gen.sv
// Directed bench for store_txn_gen with AxiDataWidth=128 (32 nibbles/beat).
// Expected bursts and beat records are hand-computed per step.
module tb_store_txn_gen;

    logic        clk    = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic [64:0] req_nb_addr;
    logic [31:0] req_nr_nbs;
    logic [3:0]  req_id;
    logic        aw_valid;
    logic        aw_ready;
    logic [63:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [3:0]  aw_id;
    logic        txn_valid;
    logic        txn_ready;
    logic [64:0] txn_addr;
    logic        txn_head;
    logic [7:0]  txn_rmn;
    logic [5:0]  txn_lbn;
    logic        txn_final;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int k;
    int cyc;
    bit hs;

    always #5 clk = ~clk;

    store_txn_gen dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_nb_addr_i     (req_nb_addr),
        .req_nr_nbs_i      (req_nr_nbs),
        .req_id_i          (req_id),
        .aw_valid_o        (aw_valid),
        .aw_ready_i        (aw_ready),
        .aw_addr_o         (aw_addr),
        .aw_len_o          (aw_len),
        .aw_size_o         (aw_size),
        .aw_burst_o        (aw_burst),
        .aw_id_o           (aw_id),
        .txn_ctrl_valid_o  (txn_valid),
        .txn_ctrl_ready_i  (txn_ready),
        .txn_addr_o        (txn_addr),
        .txn_is_head_o     (txn_head),
        .txn_rmn_beat_o    (txn_rmn),
        .txn_lbn_o         (txn_lbn),
        .txn_is_final_txn_o(txn_final),
        .busy_o            (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AW and txn_ctrl valid must never overlap; ready and busy are exclusive.
    always @(negedge clk) begin
        if (rst_ni) begin
            checks++;
            assert (!(aw_valid && txn_valid)) else begin
                errors++;
                $error("FAIL overlap observed %0b%0b expected 00", aw_valid, txn_valid);
            end
            checks++;
            assert (busy === ~req_ready) else begin
                errors++;
                $error("FAIL busy_ready observed %0b expected %0b", busy, ~req_ready);
            end
        end
    end

    task automatic send_req(input logic [64:0] a, input logic [31:0] n,
                            input logic [3:0] i);
        req_valid   = 1'b1;
        req_nb_addr = a;
        req_nr_nbs  = n;
        req_id      = i;
        @(posedge clk);
        @(negedge clk);
        req_valid   = 1'b0;
    endtask

    task automatic expect_aw(input string tag, input logic [63:0] a,
                             input logic [7:0] l, input logic [3:0] i);
        int n = 0;
        while (!aw_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_aw_valid"}, aw_valid, 1'b1);
        chk({tag, "_aw_addr"}, aw_addr, a);
        chk({tag, "_aw_len"}, aw_len, l);
        chk({tag, "_aw_id"}, aw_id, i);
        chk({tag, "_aw_size"}, aw_size, 3'd4);
        chk({tag, "_aw_burst"}, aw_burst, 2'b01);
        chk({tag, "_aw_req_ready"}, req_ready, 1'b0);
        aw_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        aw_ready = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [64:0] a,
                               input logic h, input logic [7:0] r,
                               input logic [5:0] l, input logic f);
        int n = 0;
        while (!txn_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_b_valid"}, txn_valid, 1'b1);
        chk({tag, "_b_addr"}, txn_addr, a);
        chk({tag, "_b_head"}, txn_head, h);
        chk({tag, "_b_rmn"}, txn_rmn, r);
        chk({tag, "_b_lbn"}, txn_lbn, l);
        chk({tag, "_b_final"}, txn_final, f);
        txn_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        txn_ready = 1'b0;
    endtask

    initial begin
        req_valid   = 1'b0;
        req_nb_addr = '0;
        req_nr_nbs  = '0;
        req_id      = '0;
        aw_ready    = 1'b0;
        txn_ready   = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_aw_valid", aw_valid, 1'b0);
        chk("rst_txn_valid", txn_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_aw_addr", aw_addr, 64'h0);
        chk("rst_aw_len", aw_len, 8'h0);
        chk("rst_aw_id", aw_id, 4'h0);
        chk("rst_txn_addr", txn_addr, 65'h0);
        chk("rst_lbn", txn_lbn, 6'h0);
        chk("rst_aw_size", aw_size, 3'd4);
        chk("rst_aw_burst", aw_burst, 2'b01);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // single unaligned beat, with AW latency check
        send_req(65'h006, 32'd20, 4'h3);
        chk("t1_calc_aw", aw_valid, 1'b0);
        chk("t1_calc_busy", busy, 1'b1);
        @(negedge clk);
        chk("t1_lat_aw", aw_valid, 1'b1);
        expect_aw("t1", 64'h0, 8'd0, 4'h3);
        expect_beat("t1", 65'h006, 1'b1, 8'd0, 6'd26, 1'b1);
        chk("t1_idle_ready", req_ready, 1'b1);
        chk("t1_idle_busy", busy, 1'b0);

        // unaligned multi-beat
        send_req(65'h01A, 32'd40, 4'h5);
        expect_aw("t2", 64'h0, 8'd2, 4'h5);
        expect_beat("t2_0", 65'h01A, 1'b1, 8'd2, 6'd2, 1'b1);
        expect_beat("t2_1", 65'h01A, 1'b0, 8'd1, 6'd2, 1'b1);
        expect_beat("t2_2", 65'h01A, 1'b0, 8'd0, 6'd2, 1'b1);
        chk("t2_idle_ready", req_ready, 1'b1);

        // 4 KiB crossing
        send_req(65'h1FF0, 32'd64, 4'hA);
        expect_aw("t3a", 64'hFF0, 8'd0, 4'hA);
        expect_beat("t3a", 65'h1FF0, 1'b1, 8'd0, 6'd32, 1'b0);
        chk("t3_mid_ready", req_ready, 1'b0);
        expect_aw("t3b", 64'h1000, 8'd1, 4'hA);
        expect_beat("t3b_0", 65'h2000, 1'b1, 8'd1, 6'd16, 1'b1);
        expect_beat("t3b_1", 65'h2000, 1'b0, 8'd0, 6'd16, 1'b1);
        chk("t3_idle_ready", req_ready, 1'b1);

        // 256-beat cap
        send_req(65'h0, 32'd8224, 4'h1);
        expect_aw("t4a", 64'h0, 8'd255, 4'h1);
        for (int i = 0; i < 256; i++)
            expect_beat("t4a", 65'h0, (i == 0), 8'(255 - i), 6'd32, 1'b0);
        expect_aw("t4b", 64'h1000, 8'd0, 4'h1);
        expect_beat("t4b", 65'h2000, 1'b1, 8'd0, 6'd32, 1'b1);
        chk("t4_idle_ready", req_ready, 1'b1);

        // AW held off 5 cycles, then toggling beat ready
        send_req(65'h01A, 32'd40, 4'h6);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t5_aw_hold_valid", aw_valid, 1'b1);
            chk("t5_aw_hold_addr", aw_addr, 64'h0);
            chk("t5_aw_hold_len", aw_len, 8'd2);
            chk("t5_aw_hold_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        expect_aw("t5", 64'h0, 8'd2, 4'h6);
        k   = 0;
        cyc = 0;
        while (k < 3 && cyc < 40) begin
            txn_ready = (cyc % 2 == 1);
            if (txn_valid) begin
                chk("t5_rmn", txn_rmn, 8'(2 - k));
                chk("t5_head", txn_head, (k == 0));
                chk("t5_addr", txn_addr, 65'h01A);
                chk("t5_lbn", txn_lbn, 6'd2);
                chk("t5_req_ready", req_ready, 1'b0);
            end
            hs = txn_valid && txn_ready;
            @(posedge clk);
            @(negedge clk);
            if (hs) k++;
            cyc++;
        end
        txn_ready = 1'b0;
        chk("t5_beat_count", k, 3);
        chk("t5_no_extra", txn_valid, 1'b0);
        chk("t5_idle_ready", req_ready, 1'b1);

        // zero-length request
        send_req(65'h100, 32'd0, 4'h2);
        chk("t6_ready", req_ready, 1'b1);
        chk("t6_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_aw", aw_valid, 1'b0);
            chk("t6_no_beat", txn_valid, 1'b0);
            @(negedge clk);
        end

        // reset mid-burst
        send_req(65'h0, 32'd8224, 4'h9);
        expect_aw("t7", 64'h0, 8'd255, 4'h9);
        expect_beat("t7_0", 65'h0, 1'b1, 8'd255, 6'd32, 1'b0);
        expect_beat("t7_1", 65'h0, 1'b0, 8'd254, 6'd32, 1'b0);
        rst_ni = 1'b0;
        #1;
        chk("t7_rst_txn_valid", txn_valid, 1'b0);
        chk("t7_rst_aw_valid", aw_valid, 1'b0);
        chk("t7_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("t7_rel_ready", req_ready, 1'b1);
        chk("t7_rel_aw_id", aw_id, 4'h0);
        for (int i = 0; i < 3; i++) begin
            chk("t7_rel_no_aw", aw_valid, 1'b0);
            chk("t7_rel_no_beat", txn_valid, 1'b0);
            @(negedge clk);
        end

        // normal operation after reset
        send_req(65'h006, 32'd20, 4'h7);
        expect_aw("t8", 64'h0, 8'd0, 4'h7);
        expect_beat("t8", 65'h006, 1'b1, 8'd0, 6'd26, 1'b1);
        chk("t8_idle_ready", req_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_txn_gen.md
Name: store_txn_gen

Overview:
- Upstream control stage for the vector store path.
- Takes one store request (nibble-granular start address and length) and splits it into AXI INCR bursts that respect the 4 KiB boundary and the 256-beat limit.
- For each burst it issues one AW, then one txn_ctrl record per W beat to the sequential store stage.
- The sequential store stage uses these records to place nibbles into W beats and to generate last.

Parameters:
- AxiDataWidth, 128, AXI data width in bits. busNibbles = AxiDataWidth/4; busNSize = log2(busNibbles).
- AxiAddrWidth, 64, AXI byte-address width.
- AxiIdWidth, 4, AXI ID width.
- LenWidth, 32, width of the request nibble count.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  store request valid
- req_ready_o  out  1  request accepted; high only in S_IDLE
- req_nb_addr_i  in  AxiAddrWidth+1  start nibble address (byte address << 1 | nibble select)
- req_nr_nbs_i  in  LenWidth  total nibbles to store
- req_id_i  in  AxiIdWidth  AXI ID used for all bursts of the request
- aw_valid_o  out  1  AW valid
- aw_ready_i  in  1  AW ready
- aw_addr_o  out  AxiAddrWidth  bus-aligned byte address of the burst
- aw_len_o  out  8  beats-1
- aw_size_o  out  3  constant log2(AxiDataWidth/8)
- aw_burst_o  out  2  constant INCR (2'b01)
- aw_id_o  out  AxiIdWidth  latched req_id_i
- txn_ctrl_valid_o  out  1  per-beat control valid
- txn_ctrl_ready_i  in  1  per-beat control consumed
- txn_addr_o  out  AxiAddrWidth+1  start nibble address of the current burst; constant for all beats of the burst
- txn_is_head_o  out  1  current beat is the first beat of its burst
- txn_rmn_beat_o  out  8  beats remaining in the burst after this one
- txn_lbn_o  out  busNSize+1  exclusive upper nibble index of the burst's last beat (1..busNibbles)
- txn_is_final_txn_o  out  1  current burst is the last burst of the request
- busy_o  out  1  state != S_IDLE

Behaviour:
- Reset values: all outputs 0, except aw_size_o and aw_burst_o, which are constants. req_ready_o resets to 1 because the state resets to S_IDLE. State is S_IDLE and all working registers are cleared. An asserted rst_ni low mid-operation aborts the request immediately with no further AW or txn_ctrl.
- States: S_IDLE, S_CALC, S_AW, S_BEAT.
- S_IDLE:
  - req_ready_o=1.
  - On a req handshake, latch cur_addr=req_nb_addr_i, rmn_nbs=req_nr_nbs_i, id.
  - If req_nr_nbs_i==0, stay in S_IDLE; no AW and no beats are produced. Otherwise go to S_CALC.
- S_CALC (exactly 1 cycle):
  - off = cur_addr[busNSize-1:0].
  - to4k = 8192 - cur_addr[12:0].
  - maxb = 256*busNibbles - off.
  - txn_nbs = min(rmn_nbs, to4k, maxb).
  - beats = ceil((off+txn_nbs)/busNibbles).
  - lbn = ((off+txn_nbs-1) mod busNibbles)+1.
  - final = (txn_nbs==rmn_nbs).
  - Register: aw_addr = (cur_addr>>1) with the low log2(AxiDataWidth/8) bits cleared; aw_len = beats-1; rmn_beat = beats-1; is_head=1.
  - Go to S_AW.
  - Intermediate arithmetic is LenWidth+1 bits wide so it cannot overflow.
- S_AW:
  - aw_valid_o=1; all AW fields stay stable until aw_ready_i.
  - On the handshake, go to S_BEAT.
  - Latency: req handshake in cycle N, then aw_valid_o in cycle N+2.
- S_BEAT:
  - txn_ctrl_valid_o=1; fields are stable while not ready.
  - On each handshake: is_head<=0 and rmn_beat<=rmn_beat-1.
  - On the handshake with rmn_beat==0:
    - If final, go to S_IDLE (req_ready_o=1 in the next cycle).
    - Otherwise cur_addr+=txn_nbs, rmn_nbs-=txn_nbs, then go to S_CALC.
- Ordering and overlap: AW of burst k+1 is never issued before the last txn_ctrl beat of burst k has handshaked. AW and txn_ctrl valid are never high in the same cycle.
- A request is never accepted while busy_o=1.
- Assertions:
  - txn_lbn_o is in 1..busNibbles while valid.
  - A burst never crosses a 4 KiB boundary.
  - aw_len_o+1 equals the number of txn_ctrl beats issued for that burst.

Test Plan:
All cases use AxiDataWidth=128, so busNibbles=32.
- Single unaligned beat: addr=0x006, nbs=20 -> AW addr 0x0 len 0; one beat: head=1, rmn=0, lbn=26, final=1, txn_addr 0x006.
- Unaligned multi-beat: addr=0x01A, nbs=40 -> AW addr 0x0 len 2; beats rmn 2,1,0; head only on the first; lbn=2; final=1.
- 4 KiB crossing: addr=0x1FF0, nbs=64 -> burst 1: AW 0xFF0 len 0, lbn=32, final=0. Burst 2: AW 0x1000 len 1, txn_addr 0x2000, lbn=16, final=1.
- Beat cap: addr=0, nbs=8224 -> AW 0x0 len 255 with 256 beats, then AW 0x1000 len 0, lbn=32, final=1.
- Backpressure: aw_ready_i low 5 cycles, txn_ctrl_ready_i toggling -> fields stable while valid; no beat lost or duplicated; req_ready_o stays 0 until the last beat.
- Zero length and reset: nbs=0 -> accepted with no AW and no beats, back in S_IDLE the next cycle. rst_ni low mid-burst -> all valids 0 and req_ready_o=1 after release.
